// File: rtl/mem_fetch_unit.sv
// mem_fetch_unit
// Unified instruction/data memory for the multicycle RISC-V core. This block
// holds the following:
//   - the word-addressed memory
//   - the instruction register (IR)
//   - the old-PC register
//   - the data register
// It decodes the opcode fields for the controller, steers store bytes into
// the right lanes, and extracts and extends load values. It also flags
// misaligned stores.
//
// Ports
//   clk       : single clock, rising edge
//   reset     : asynchronous, active-low reset
//   pc        : fetch address
//   result    : data address from the ALU/result bus
//   adrsrc    : 0 = address from pc, 1 = address from result
//   irwrite   : capture fetched word into IR and pc into oldpc
//   memwrite  : store enable (width taken from IR funct3)
//   wdata     : unshifted store data
//   instr     : IR contents
//   oldpc     : PC of the instruction held in the IR
//   op/funct3/funct7b5 : fields decoded from the IR
//   load_data : extracted/extended load value from the data register
//   fault     : sticky misaligned-store flag
module mem_fetch_unit #(
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] result,
  input  logic        adrsrc,
  input  logic        irwrite,
  input  logic        memwrite,
  input  logic [31:0] wdata,
  output logic [31:0] instr,
  output logic [31:0] oldpc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [31:0] load_data,
  output logic        fault
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   addr;
  logic [AW-1:0] index;
  logic [31:0]   rword;
  logic [31:0]   dreg;
  logic [1:0]    dlo;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic          misaligned;
  logic          unused_addr_bits;

  assign addr  = adrsrc ? result : pc;
  // Upper address bits are dropped, so accesses wrap modulo the memory size.
  assign index = addr[AW+1:2];
  assign rword = mem[index];
  assign unused_addr_bits = ^addr[31:AW+2];

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

  // Store steering. The data is replicated across lanes so that only the
  // lane enables depend on the address. A misaligned sh/sw enables no lanes.
  always_comb begin
    lane_en    = 4'b0000;
    lane_data  = 32'h0;
    misaligned = 1'b0;
    case (funct3)
      3'b000: begin
        lane_en   = 4'b0001 << addr[1:0];
        lane_data = {4{wdata[7:0]}};
      end
      3'b001: begin
        lane_data = {2{wdata[15:0]}};
        if (addr[0]) misaligned = 1'b1;
        else         lane_en    = addr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        lane_data = wdata;
        if (addr[1:0] != 2'b00) misaligned = 1'b1;
        else                    lane_en    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Memory is not reset. A store whose edge arrives while reset is low is
  // dropped by qualifying the write with the reset level.
  always_ff @(posedge clk) begin
    if (memwrite && reset) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[index][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  // IR, old PC, data register and fault flag. The IR and the data register
  // sample rword before any same-edge store lands, which gives
  // read-before-write behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= 32'h0000_0013;
      oldpc <= 32'h0;
      dreg  <= 32'h0;
      dlo   <= 2'b00;
      fault <= 1'b0;
    end else begin
      if (irwrite) begin
        instr <= rword;
        oldpc <= pc;
      end
      dreg <= rword;
      dlo  <= addr[1:0];
      if (memwrite && misaligned) fault <= 1'b1;
    end
  end

  // Load extraction from the data register. Lane bits are used as given,
  // so misaligned loads are not detected.
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = dreg[8*dlo +: 8];
    load_half = dlo[1] ? dreg[31:16] : dreg[15:0];
    case (funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b010:  load_data = dreg;
      3'b100:  load_data = {24'h0, load_byte};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = dreg;
    endcase
  end

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Testbench for mem_fetch_unit. It runs the directed scenarios first and
// then a randomized run. Every cycle is compared against a word-level model
// of the memory, the IR, the old PC, the data register and the fault flag.
module tb_mem_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] result;
  logic        adrsrc;
  logic        irwrite;
  logic        memwrite;
  logic [31:0] wdata;
  logic [31:0] instr;
  logic [31:0] oldpc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] load_data;
  logic        fault;

  int checks;
  int failures;

  // Reference state
  logic [31:0] m_mem [1024];
  logic [31:0] m_instr;
  logic [31:0] m_oldpc;
  logic [31:0] m_dreg;
  logic [1:0]  m_dlo;
  logic        m_fault;

  mem_fetch_unit #(.MEM_WORDS(1024), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .pc(pc), .result(result), .adrsrc(adrsrc),
    .irwrite(irwrite), .memwrite(memwrite), .wdata(wdata), .instr(instr),
    .oldpc(oldpc), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .load_data(load_data), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load: shift the selected byte or halfword down, then extend it.
  function automatic logic [31:0] modelLoad(input logic [31:0] d, input logic [1:0] lo,
                                            input logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * int'(lo))) & 32'hFF;
    h = (d >> (16 * int'(lo[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  task automatic modelReset();
    m_instr = 32'h0000_0013;
    m_oldpc = 0;
    m_dreg  = 0;
    m_dlo   = 0;
    m_fault = 0;
  endtask

  // One rising edge of the reference, applied using the state from before the edge.
  task automatic modelStep(input logic [31:0] pcv, input logic [31:0] resv, input logic adr,
                           input logic irw, input logic mw, input logic [31:0] wd);
    logic [31:0] a;
    logic [31:0] rw;
    logic [31:0] mask;
    logic [31:0] data;
    logic [2:0]  f3;
    int          idx;
    int          lo;
    a   = adr ? resv : pcv;
    idx = int'((a >> 2) % 1024);
    lo  = int'(a % 4);
    rw  = m_mem[idx];
    f3  = m_instr[14:12];
    if (mw) begin
      if ((f3 == 3'd1 && (lo % 2) != 0) || (f3 == 3'd2 && lo != 0)) begin
        m_fault = 1'b1;
      end else if (f3 <= 3'd2) begin
        if (f3 == 3'd0) begin
          mask = 32'hFF << (8 * lo);
          data = (wd & 32'hFF) << (8 * lo);
        end else if (f3 == 3'd1) begin
          mask = 32'hFFFF << (16 * (lo / 2));
          data = (wd & 32'hFFFF) << (16 * (lo / 2));
        end else begin
          mask = 32'hFFFF_FFFF;
          data = wd;
        end
        m_mem[idx] = (m_mem[idx] & ~mask) | (data & mask);
      end
    end
    if (irw) begin
      m_instr = rw;
      m_oldpc = pcv;
    end
    m_dreg = rw;
    m_dlo  = lo[1:0];
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, " instr"}, instr, m_instr);
    checkOutput({tag, " oldpc"}, oldpc, m_oldpc);
    checkOutput({tag, " op"}, {25'h0, op}, {25'h0, m_instr[6:0]});
    checkOutput({tag, " funct3"}, {29'h0, funct3}, {29'h0, m_instr[14:12]});
    checkOutput({tag, " funct7b5"}, {31'h0, funct7b5}, {31'h0, m_instr[30]});
    checkOutput({tag, " load_data"}, load_data, modelLoad(m_dreg, m_dlo, m_instr[14:12]));
    checkOutput({tag, " fault"}, {31'h0, fault}, {31'h0, m_fault});
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    dut.mem[idx] = v;
    m_mem[idx]   = v;
  endtask

  // Drive one cycle's inputs at the falling edge, step the model at the
  // rising edge, and compare just after that edge.
  task automatic applyStimulus(input logic rstv, input logic [31:0] pcv, input logic [31:0] resv,
                               input logic adr, input logic irw, input logic mw,
                               input logic [31:0] wd, input string tag);
    @(negedge clk);
    reset    = rstv;
    pc       = pcv;
    result   = resv;
    adrsrc   = adr;
    irwrite  = irw;
    memwrite = mw;
    wdata    = wd;
    if (!rstv) modelReset();
    @(posedge clk);
    if (rstv) modelStep(pcv, resv, adr, irw, mw, wd);
    #1;
    compareAll(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    pc       = 0;
    result   = 0;
    adrsrc   = 0;
    irwrite  = 0;
    memwrite = 0;
    wdata    = 0;
    for (int i = 0; i < 1024; i++) preload(i, $urandom);

    // Hold reset low and check the reset state.
    #2 reset = 1'b0;
    modelReset();
    #1;
    compareAll("reset");
    checkOutput("reset instr", instr, 32'h0000_0013);
    checkOutput("reset op", {25'h0, op}, 32'h13);
    checkOutput("reset load_data", load_data, 32'h0);

    // Fetch from pc=8.
    preload(2, 32'h00A2_8213);
    preload(3, 32'h0000_4283);  // lbu
    preload(4, 32'h1122_3344);
    preload(6, 32'h0000_1283);  // lh
    preload(7, 32'h0000_5283);  // lhu
    preload(8, 32'h0000_2023);  // sw
    preload(0, 32'h0000_2023);
    applyStimulus(1, 32'h8, 0, 0, 1, 0, 0, "fetch");
    checkOutput("fetch instr", instr, 32'h00A2_8213);
    checkOutput("fetch oldpc", oldpc, 32'h8);
    checkOutput("fetch funct3", {29'h0, funct3}, 32'h0);

    // Byte store, then signed and unsigned byte loads.
    applyStimulus(1, 0, 32'h12, 1, 0, 1, 32'hFFFF_FF80, "sb");
    applyStimulus(1, 0, 32'h12, 1, 0, 0, 0, "lb read");
    checkOutput("lb value", load_data, 32'hFFFF_FF80);
    applyStimulus(1, 32'hC, 0, 0, 1, 0, 0, "fetch lbu");
    applyStimulus(1, 0, 32'h12, 1, 0, 0, 0, "lbu read");
    checkOutput("lbu value", load_data, 32'h0000_0080);

    // Halfword loads.
    preload(4, 32'h8001_ABCD);
    applyStimulus(1, 32'h18, 0, 0, 1, 0, 0, "fetch lh");
    applyStimulus(1, 0, 32'h12, 1, 0, 0, 0, "lh read");
    checkOutput("lh value", load_data, 32'hFFFF_8001);
    applyStimulus(1, 32'h1C, 0, 0, 1, 0, 0, "fetch lhu");
    applyStimulus(1, 0, 32'h10, 1, 0, 0, 0, "lhu read");
    checkOutput("lhu value", load_data, 32'h0000_ABCD);

    // Misaligned sw is suppressed and sets the sticky fault flag.
    applyStimulus(1, 32'h20, 0, 0, 1, 0, 0, "fetch sw");
    applyStimulus(1, 0, 32'h13, 1, 0, 1, 32'hDEAD_BEEF, "sw misaligned");
    checkOutput("misaligned fault", {31'h0, fault}, 32'h1);
    applyStimulus(1, 0, 32'h10, 1, 0, 0, 0, "lw after bad sw");
    checkOutput("mem4 unchanged", load_data, 32'h8001_ABCD);
    applyStimulus(1, 0, 32'h10, 1, 0, 1, 32'h1234_5678, "sw aligned");
    checkOutput("fault sticky", {31'h0, fault}, 32'h1);
    applyStimulus(1, 0, 32'h10, 1, 0, 0, 0, "lw after sw");
    checkOutput("sw value", load_data, 32'h1234_5678);

    // Wrapped address with a same-edge fetch (read-before-write).
    applyStimulus(1, 32'h40, 32'h1000, 1, 1, 1, 32'hCAFE_F00D, "collision");
    checkOutput("collision instr", instr, 32'h0000_2023);
    checkOutput("collision oldpc", oldpc, 32'h40);
    checkOutput("collision dreg", load_data, 32'h0000_2023);
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 0, "read after wrap");
    checkOutput("wrap value", load_data, 32'hCAFE_F00D);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 reset = 1'b0;
    modelReset();
    #1;
    compareAll("async reset");
    checkOutput("async instr", instr, 32'h0000_0013);
    checkOutput("async fault", {31'h0, fault}, 32'h0);
    // A store whose edge lands while reset is low is dropped.
    applyStimulus(0, 0, 32'h10, 1, 0, 1, 32'hBAD0_BAD0, "store in reset");
    applyStimulus(1, 32'h20, 0, 0, 1, 0, 0, "refetch sw");
    applyStimulus(1, 0, 32'h10, 1, 0, 0, 0, "read after reset");
    checkOutput("store in reset dropped", load_data, 32'h1234_5678);

    // Randomized run over a small set of word addresses with random upper bits.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pcv;
      logic [31:0] resv;
      pcv  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      resv = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      applyStimulus(($urandom_range(0, 149) != 0), pcv, resv, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
